resp_compactor: RTL
===================

RESP_COMPACTOR -- requirements
Module: resp_compactor

Interface
REQ-001 SHALL have parameter WINDOW, default 32, meaning samples compacted per window (legal range 1..65535).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the toggle counter.
REQ-003 SHALL have port CK  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports r1, r2, r3  input  1 each  response bits, driven by out1, out2 and out3 of the upstream circuit under test.
REQ-006 SHALL have port start  input  1  request to begin a compaction window.
REQ-007 SHALL have port ack  input  1  consumer acknowledge of a finished result.
REQ-008 SHALL have port sig  output  16  MISR signature.
REQ-009 SHALL have port tcnt  output  CNT_W  count of samples that differ from the previous sample.
REQ-010 SHALL have port valid  output  1  sig and tcnt hold a finished window result.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and HOLD.
REQ-012 IDLE with start=1 at an edge SHALL go to RUN and load:
  - sig=16'hFFFF
  - tcnt=0
  - sample counter=0
  - prev={r3,r2,r1}
  No MISR update takes place on this edge.
REQ-013 In RUN, each edge SHALL capture s={r3,r2,r1}.
REQ-014 In RUN, each edge SHALL set sig <= {sig[14:0], fb} XOR {13'b0, s}, where fb = sig[15]^sig[13]^sig[12]^sig[10].
REQ-015 In RUN, each edge where s != prev SHALL increment tcnt, saturating at 2^CNT_W-1; prev <= s on every RUN edge.
REQ-016 The edge capturing the WINDOW-th sample SHALL move the FSM to HOLD; valid SHALL be 1 from the following cycle.
REQ-017 In HOLD, sig, tcnt and valid=1 SHALL stay stable until ack=1 is sampled.
REQ-018 In HOLD with ack=1 and start=0, the FSM SHALL go to IDLE and valid SHALL drop on the same edge.
REQ-019 In HOLD with ack=1 and start=1, the FSM SHALL go directly to RUN and perform the REQ-012 loads.
REQ-020 start SHALL be ignored in RUN, and in HOLD without ack.
REQ-021 ack SHALL be ignored in IDLE and RUN.
REQ-022 In IDLE, sig and tcnt SHALL retain the last result and valid SHALL be 0.
REQ-023 The sample counter SHALL be 16 bits and SHALL not wrap within a window.

Reset
REQ-024 RST=1 SHALL immediately force all of the following, regardless of CK, including mid-window and during HOLD:
  - state IDLE
  - valid=0
  - sig=16'hFFFF
  - tcnt=0
  - prev=0
  - sample counter=0
REQ-025 After RST deasserts, the block SHALL take no action until start is sampled in IDLE.

Structure
REQ-026 A package resp_compactor_pkg SHALL hold:
  - SIG_W=16
  - MISR_SEED=16'hFFFF
  - the tap set {15,13,12,10}
  - the state enum
REQ-027 MISR next-state logic SHALL be one sub-module, misr16, with ports CK, RST, load, en, d[2:0] and q[15:0].

Verification
REQ-028 WINDOW=4; start pulse; r1=r2=r3=0 held -> valid rises 5 edges after start with sig=16'hFFF0 and tcnt=0.
REQ-029 WINDOW=4; r1=0 at start, then r1=1,0,1,0 on the four RUN edges -> tcnt=4 when valid=1.
REQ-030 CNT_W=2, WINDOW=8; r2 toggling every cycle -> tcnt saturates at 3 and stays 3 until ack.
REQ-031 In HOLD, with ack held 0 for 10 cycles while inputs and start toggle -> sig, tcnt and valid unchanged; then ack=1 with start=1 -> next cycle valid=0, state RUN, sig=16'hFFFF.
REQ-032 RST pulsed asynchronously (between edges) at sample 2 of a WINDOW=4 run -> valid=0, sig=16'hFFFF and tcnt=0 immediately; no valid occurs without a new start.
REQ-033 ack asserted in IDLE and RUN -> no effect on state or outputs.

Source files
------------

// File: rtl/resp_compactor_pkg.sv
// resp_compactor_pkg: shared widths, MISR constants and FSM state type
package resp_compactor_pkg;
    localparam int              SIG_W     = 16;
    localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;
    // feedback taps at bits 15, 13, 12 and 10
    localparam logic [SIG_W-1:0] MISR_TAPS = 16'hB400;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
endpackage

// File: rtl/misr16.sv
// misr16: 16-bit multiple-input signature register with seed load and 3-bit parallel input
module misr16
    import resp_compactor_pkg::*;
(
    input  logic             CK,
    input  logic             RST,
    input  logic             load,
    input  logic             en,
    input  logic [2:0]       d,
    output logic [SIG_W-1:0] q
);
    logic [SIG_W-1:0] r_q;
    logic             w_fb;
    assign w_fb = ^(r_q & MISR_TAPS);
    assign q    = r_q;
    // seed on reset or load, otherwise shift in feedback and fold the sample into the low bits
    always_ff @(posedge CK or posedge RST)
        if (RST)
            r_q <= MISR_SEED;
        else if (load)
            r_q <= MISR_SEED;
        else if (en)
            r_q <= {r_q[SIG_W-2:0], w_fb} ^ {{(SIG_W-3){1'b0}}, d};
endmodule

// File: rtl/resp_compactor.sv
// resp_compactor: compacts 3-bit response samples into a MISR signature and a toggle count per window
module resp_compactor
    import resp_compactor_pkg::*;
#(
    parameter int WINDOW = 32,
    parameter int CNT_W  = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             r1,
    input  logic             r2,
    input  logic             r3,
    input  logic             start,
    input  logic             ack,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] tcnt,
    output logic             valid
);
    localparam logic [15:0]      LAST = 16'(WINDOW - 1);
    localparam logic [CNT_W-1:0] TMAX = '1;
    state_t           r_state;
    logic [2:0]       r_prev;
    logic [15:0]      r_cnt;
    logic [CNT_W-1:0] r_tcnt;
    logic             r_valid;
    logic [2:0]       w_s;
    logic             w_run;
    logic             w_load;
    assign w_s    = {r3, r2, r1};
    assign w_run  = r_state == RUN;
    assign w_load = start && (r_state == IDLE || (r_state == HOLD && ack));
    assign tcnt   = r_tcnt;
    assign valid  = r_valid;
    misr16 u_misr (
        .CK   (CK),
        .RST  (RST),
        .load (w_load),
        .en   (w_run),
        .d    (w_s),
        .q    (sig)
    );
    // window FSM: start a window, count toggles and samples, hold the result until acknowledged
    always_ff @(posedge CK or posedge RST)
        if (RST) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_tcnt  <= '0;
            r_prev  <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_state <= RUN;
            r_valid <= 1'b0;
            r_tcnt  <= '0;
            r_cnt   <= '0;
            r_prev  <= w_s;
        end else if (w_run) begin
            r_prev <= w_s;
            r_cnt  <= r_cnt + 16'd1;
            if (w_s != r_prev && r_tcnt != TMAX)
                r_tcnt <= r_tcnt + 1'b1;
            if (r_cnt == LAST) begin
                r_state <= HOLD;
                r_valid <= 1'b1;
            end
        end else if (r_state != IDLE && (r_state != HOLD || ack)) begin
            // acknowledged hold, or an unused encoding, returns to idle keeping sig/tcnt
            r_state <= IDLE;
            r_valid <= 1'b0;
        end
endmodule
